// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode encoding and PWM width for the LED pattern block
package led_pattern_pkg;
  typedef enum logic [1:0] {
    SHIFT_L  = 2'd0,
    SHIFT_R  = 2'd1,
    PINGPONG = 2'd2,
    FILL     = 2'd3
  } mode_e;
  localparam int NB_PWM = 4;
  localparam logic DIR_L = 1'b1;
endpackage

// File: rtl/led_pattern_if.sv
// led_pattern_if: control/pattern bundle between a controller (master) and led_pattern (slave)
//   i_enable run/freeze, i_mode pattern select, i_speed period select,
//   i_channel_sel displaying channel, i_duty PWM brightness,
//   o_led raw pattern, o_led_ch per-channel pattern, o_step advance pulse
interface led_pattern_if
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int N_CHANNELS = 3
) ();
  logic                                 i_enable;
  logic [1:0]                           i_mode;
  logic [1:0]                           i_speed;
  logic [$clog2(N_CHANNELS)-1:0]        i_channel_sel;
  logic [NB_PWM-1:0]                    i_duty;
  logic [N_LEDS-1:0]                    o_led;
  logic [N_CHANNELS-1:0][N_LEDS-1:0]    o_led_ch;
  logic                                 o_step;
  modport master (
    output i_enable, i_mode, i_speed, i_channel_sel, i_duty,
    input  o_led, o_led_ch, o_step
  );
  modport slave (
    input  i_enable, i_mode, i_speed, i_channel_sel, i_duty,
    output o_led, o_led_ch, o_step
  );
endinterface

// File: rtl/led_pattern_tick.sv
// led_pattern_tick: step prescaler, one advance every (LIMIT_BASE << speed) cycles
//   i_clock, i_reset : clock, asynchronous active-low reset
//   en_i, speed_i    : run/freeze, period select
//   clr_i            : clear the count with no step (pattern reload)
//   adv_o            : combinational advance strobe for the pattern register
//   step_o           : registered one-cycle pulse, aligned with the pattern advance
module led_pattern_tick #(
  parameter int NB_COUNTER = 32,
  parameter int LIMIT_BASE = 2**20
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       en_i,
  input  logic [1:0] speed_i,
  input  logic       clr_i,
  output logic       adv_o,
  output logic       step_o
);
  logic [NB_COUNTER-1:0] count_q, count_d, limit;
  logic                  step_q;
  assign limit = (NB_COUNTER'(LIMIT_BASE) << speed_i) - NB_COUNTER'(1);
  assign adv_o = en_i && !clr_i && count_q == limit;
  // a count left above a freshly shortened limit restarts from 0 without stepping
  assign count_d = clr_i || (en_i && count_q >= limit) ? '0
                 : en_i ? count_q + NB_COUNTER'(1) : count_q;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= adv_o;
    end
  assign step_o = step_q;
endmodule

// File: rtl/led_pattern.sv
// led_pattern: rotating / ping-pong / fill LED pattern generator with channel select
//   i_clock, i_reset : clock, asynchronous active-low reset
//   bus (slave)      : enable, mode, speed, channel select, duty in; led, led_ch, step out
//   LED_PATTERN_PWM_EN: when defined, gates o_led_ch with a free-running 4-bit PWM against i_duty
module led_pattern
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS     = 4,
  parameter int N_CHANNELS = 3,
  parameter int NB_COUNTER = 32,
  parameter int LIMIT_BASE = 2**20
) (
  input logic          i_clock,
  input logic          i_reset,
  led_pattern_if.slave bus
);
  localparam logic [N_LEDS-1:0] SEED = N_LEDS'(1);
  mode_e             mode_q;
  logic [N_LEDS-1:0] pat_q, pat_d, gated;
  logic              dir_q, dir_d, mode_chg, adv;
  assign mode_chg = mode_e'(bus.i_mode) != mode_q;
  led_pattern_tick #(
    .NB_COUNTER (NB_COUNTER),
    .LIMIT_BASE (LIMIT_BASE)
  ) u_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .en_i    (bus.i_enable),
    .speed_i (bus.i_speed),
    .clr_i   (mode_chg),
    .adv_o   (adv),
    .step_o  (bus.o_step)
  );
  // ping-pong turns around on reaching either end so the end position is shown once
  always_comb begin
    dir_d = mode_q != PINGPONG ? dir_q : pat_q[N_LEDS-1] ? ~DIR_L : pat_q[0] ? DIR_L : dir_q;
    pat_d = pat_q;
    case (mode_q)
      SHIFT_L:  pat_d = {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
      SHIFT_R:  pat_d = {pat_q[0], pat_q[N_LEDS-1:1]};
      PINGPONG: pat_d = dir_d == DIR_L ? pat_q << 1 : pat_q >> 1;
      FILL:     pat_d = &pat_q ? '0 : {pat_q[N_LEDS-2:0], 1'b1};
      default:  pat_d = pat_q;
    endcase
  end
  // mode copy loads the live mode in reset so releasing reset never looks like a mode change
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      mode_q <= mode_e'(bus.i_mode);
      pat_q  <= SEED;
      dir_q  <= DIR_L;
    end else if (mode_chg) begin
      mode_q <= mode_e'(bus.i_mode);
      pat_q  <= SEED;
      dir_q  <= DIR_L;
    end else if (adv) begin
      pat_q  <= pat_d;
      dir_q  <= dir_d;
    end
`ifdef LED_PATTERN_PWM_EN
  logic [NB_PWM-1:0] pwm_q;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) pwm_q <= '0;
    else pwm_q <= pwm_q + NB_PWM'(1);
  assign gated = pwm_q < bus.i_duty ? pat_q : '0;
`else
  logic unused_duty;
  assign unused_duty = ^bus.i_duty;
  assign gated = pat_q;
`endif
  assign bus.o_led = pat_q;
  always_comb begin
    bus.o_led_ch = '0;
    for (int c = 0; c < N_CHANNELS; c++)
      bus.o_led_ch[c] = int'(bus.i_channel_sel) == c ? gated : '0;
  end
endmodule

// File: tb/tb_led_pattern.sv
// tb_led_pattern: directed + random bench for led_pattern against a step-index reference model
module tb_led_pattern;
  localparam int N  = 4;
  localparam int NC = 3;
  localparam int LB = 4;
  logic clk = 1'b0;
  logic rst_n;
  int   n_err = 0;
  int   n_chk = 0;
  int   m_mode, m_k, m_count, m_pwm;
  bit   m_step;
  always #5 clk = ~clk;
  led_pattern_if #(.N_LEDS(N), .N_CHANNELS(NC)) bus ();
  led_pattern #(
    .N_LEDS     (N),
    .N_CHANNELS (NC),
    .NB_COUNTER (32),
    .LIMIT_BASE (LB)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );
  // pattern after k steps from the seed, straight from the sequence definitions
  function automatic logic [N-1:0] exp_pat(input int mode, input int k);
    int p, r;
    p = k % (2 * N - 2);
    r = (k + 1) % (N + 1);
    case (mode)
      0:       return N'(1) << (k % N);
      1:       return N'(1) << ((N - k % N) % N);
      2:       return N'(1) << (p < N ? p : 2 * N - 2 - p);
      default: return N'((1 << r) - 1);
    endcase
  endfunction
  function automatic int lim_now();
    return (LB << bus.i_speed) - 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_mode  = int'(bus.i_mode);
    m_k     = 0;
    m_count = 0;
    m_pwm   = 0;
    m_step  = 0;
  endtask
  task automatic model_update();
    int lim;
    lim = lim_now();
    if (!rst_n) begin
      m_mode = int'(bus.i_mode);
      return;
    end
    m_pwm = (m_pwm + 1) % 16;
    if (int'(bus.i_mode) != m_mode) begin
      m_mode  = int'(bus.i_mode);
      m_k     = 0;
      m_count = 0;
      m_step  = 0;
    end else if (!bus.i_enable) begin
      m_step = 0;
    end else if (m_count == lim) begin
      m_count = 0;
      m_k++;
      m_step = 1;
    end else begin
      m_count = m_count > lim ? 0 : m_count + 1;
      m_step  = 0;
    end
  endtask
  task automatic check_all(input string tag);
    logic [N-1:0]    ep, g;
    logic [NC*N-1:0] ech;
    ep = exp_pat(m_mode, m_k);
`ifdef LED_PATTERN_PWM_EN
    g = m_pwm < int'(bus.i_duty) ? ep : '0;
`else
    g = ep;
`endif
    ech = '0;
    for (int c = 0; c < NC; c++)
      if (int'(bus.i_channel_sel) == c) ech[c*N +: N] = g;
    chk({tag, ".led"},   32'(bus.o_led),           32'(ep));
    chk({tag, ".step"},  32'(bus.o_step),          32'(m_step));
    chk({tag, ".ch"},    32'(bus.o_led_ch),        32'(ech));
    chk({tag, ".count"}, 32'(dut.u_tick.count_q),  32'(m_count));
  endtask
  task automatic cyc(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    rst_n             = 1'b1;
    bus.i_enable      = 1'b1;
    bus.i_mode        = 2'd0;
    bus.i_speed       = 2'd0;
    bus.i_channel_sel = 2'd0;
    bus.i_duty        = 4'd4;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    repeat (3) cyc("reset_hold");
    rst_n = 1'b1;
    repeat (17) cyc("shift_l");
    bus.i_mode = 2'd2;
    repeat (34) cyc("pingpong");
    bus.i_mode = 2'd3;
    repeat (25) cyc("fill");
    for (int i = 0; i < 64 && m_count != lim_now(); i++) cyc("fill_align");
    bus.i_mode = 2'd1;
    cyc("mode_at_step");
    chk("mode_at_step.seed", 32'(bus.o_led), 32'(4'b0001));
    repeat (9) cyc("shift_r");
    bus.i_speed = 2'd2;
    for (int i = 0; i < 64 && m_count != 10; i++) cyc("speed2");
    bus.i_speed = 2'd0;
    repeat (6) cyc("speed_drop");
    bus.i_enable = 1'b0;
    repeat (20) cyc("freeze");
    bus.i_enable = 1'b1;
    for (int s = 1; s < 4; s++) begin
      bus.i_channel_sel = 2'(s);
      repeat (5) cyc("chsel");
    end
    bus.i_channel_sel = 2'd1;
    repeat (2) cyc("pre_rst");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    repeat (2) cyc("rst_mid_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) bus.i_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.i_speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) bus.i_enable = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) == 0) bus.i_channel_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) bus.i_duty = 4'($urandom_range(0, 15));
      cyc("rand");
    end
    bus.i_enable      = 1'b1;
    bus.i_channel_sel = 2'd0;
    bus.i_duty        = 4'd0;
    repeat (20) cyc("duty0");
    bus.i_duty = 4'd15;
    repeat (20) cyc("duty15");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
